// File: rtl/switch_event_arbiter.sv
// Round-robin arbiter: latches debounced switch change pulses and
// issues them one at a time on a valid/ready event port.
// Optional: define SWEVT_TIMESTAMP_EN to stamp each event with a cycle count.
module switch_event_arbiter #(
  parameter int N_SW  = 18,
  parameter int IDX_W = 5,
  parameter int TS_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SW-1:0]  sw_stable,
  input  logic [N_SW-1:0]  sw_changed,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_idx,
  output logic             evt_level,
  input  logic             ovr_clr,
  output logic [N_SW-1:0]  ovr_flags,
  output logic [TS_W-1:0]  evt_time
);

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [N_SW-1:0]  pend_q, pend_d;
  logic [N_SW-1:0]  lvl_q, lvl_d;
  logic [N_SW-1:0]  ovr_q, ovr_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             level_q, level_d;

  logic             any_pend;
  logic             found;
  logic [IDX_W-1:0] win;
  logic             load;
  logic [N_SW-1:0]  gnt;

  assign any_pend = |pend_q;

  // Pick the first pending bit at or above rr_q, else the lowest one.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N_SW; i++) begin
      if (!found && pend_q[i] && (IDX_W'(i) >= rr_q)) begin
        found = 1'b1;
        win   = IDX_W'(i);
      end
    end
    for (int i = 0; i < N_SW; i++) begin
      if (!found && pend_q[i]) begin
        found = 1'b1;
        win   = IDX_W'(i);
      end
    end
  end

  // Output-slot FSM: decide when a winner is loaded.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    level_d = level_q;
    rr_d    = rr_q;
    load    = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (any_pend) begin
          load    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (evt_ready) begin
          if (any_pend) begin
            load = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
    if (load) begin
      valid_d = 1'b1;
      idx_d   = win;
      level_d = lvl_q[win];
      if (win == IDX_W'(N_SW - 1)) begin
        rr_d = '0;
      end else begin
        rr_d = win + 1'b1;
      end
    end
  end

  // Pending/level capture; a new pulse beats a same-edge grant clear.
  always_comb begin
    gnt = '0;
    if (load) begin
      gnt[win] = 1'b1;
    end
    pend_d = (pend_q & ~gnt) | sw_changed;
    lvl_d  = (lvl_q & ~sw_changed) | (sw_stable & sw_changed);
    ovr_d  = (ovr_q & ~{N_SW{ovr_clr}})
           | (sw_changed & pend_q & ~gnt);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      pend_q  <= '0;
      lvl_q   <= '0;
      ovr_q   <= '0;
      rr_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      lvl_q   <= lvl_d;
      ovr_q   <= ovr_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      level_q <= level_d;
    end
  end

  assign evt_valid = valid_q;
  assign evt_idx   = idx_q;
  assign evt_level = level_q;
  assign ovr_flags = ovr_q;

`ifdef SWEVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] time_q;

  // Free-running cycle counter, sampled when a winner loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q   <= '0;
      time_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (load) begin
        time_q <= ts_q;
      end
    end
  end

  assign evt_time = time_q;
`else
  assign evt_time = '0;
`endif

endmodule

// File: tb/tb_switch_event_arbiter.sv
// Bench for switch_event_arbiter: scoreboard of expected events,
// table of pulse vectors plus hand-written corner sequences.
module tb_switch_event_arbiter;

  localparam int N = 18;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  sw_stable;
  logic [N-1:0]  sw_changed;
  logic          evt_ready;
  logic          evt_valid;
  logic [4:0]    evt_idx;
  logic          evt_level;
  logic          ovr_clr;
  logic [N-1:0]  ovr_flags;
  logic [15:0]   evt_time;

  switch_event_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_stable  (sw_stable),
    .sw_changed (sw_changed),
    .evt_ready  (evt_ready),
    .evt_valid  (evt_valid),
    .evt_idx    (evt_idx),
    .evt_level  (evt_level),
    .ovr_clr    (ovr_clr),
    .ovr_flags  (ovr_flags),
    .evt_time   (evt_time)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] idx;
    logic       lvl;
  } ev_t;

  typedef struct {
    logic [N-1:0] chg;
    logic [N-1:0] lvl;
    int           first;
  } vec_t;

  ev_t  q[$];
  vec_t vt[5];
  int   checks;
  int   failures;
  int   mrr;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int i, input logic l);
    ev_t e;
    e.idx = 5'(i);
    e.lvl = l;
    q.push_back(e);
  endtask

  // Monitor at the falling edge, then advance to 1 ns past the rising edge.
  task automatic tick();
    ev_t e;
    @(negedge clk);
    if (rst_n && evt_valid && evt_ready) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_evt idx=%0d lvl=%0b expected=none",
                 evt_idx, evt_level);
      end else begin
        e = q.pop_front();
        if (evt_idx !== e.idx || evt_level !== e.lvl) begin
          failures++;
          $display("FAIL evt actual=%0d/%0b expected=%0d/%0b",
                   evt_idx, evt_level, e.idx, e.lvl);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] chg, input logic [N-1:0] lvl);
    sw_changed = chg;
    sw_stable  = (sw_stable & ~chg) | (lvl & chg);
    tick();
    sw_changed = '0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout left=%0d expected=0", name, q.size());
      q.delete();
    end
    tick();
    chk({name, "_idle"}, 32'(evt_valid), 32'd0);
  endtask

  // Expected order for one pulse burst into an idle arbiter.
  task automatic model_push(input logic [N-1:0] chg, input logic [N-1:0] lvl);
    int j;
    int last;
    last = mrr;
    for (int k = 0; k < N; k++) begin
      j = (mrr + k) % N;
      if (chg[j]) begin
        push_ev(j, lvl[j]);
        last = j;
      end
    end
    mrr = (last + 1) % N;
  endtask

  initial begin
    int cnt;
    int first;
    int last;
    int n;
    logic [15:0] t1;
    logic [15:0] t2;

    vt[0] = '{chg: 18'h00044, lvl: 18'h00004, first: 6};
    vt[1] = '{chg: 18'h20009, lvl: 18'h20000, first: 3};
    vt[2] = '{chg: 18'h00002, lvl: 18'h00002, first: 1};
    vt[3] = '{chg: 18'h10001, lvl: 18'h00001, first: 16};
    vt[4] = '{chg: 18'h3FFFF, lvl: 18'h15555, first: 1};

    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    sw_stable  = '0;
    sw_changed = '0;
    evt_ready  = 1'b1;
    ovr_clr    = 1'b0;
    tick();
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_idx", 32'(evt_idx), 32'd0);
    chk("rst_level", 32'(evt_level), 32'd0);
    chk("rst_ovr", 32'(ovr_flags), 32'd0);
    chk("rst_time", 32'(evt_time), 32'd0);
    tick();
    #3 rst_n = 1'b1;
    tick();

    // All 18 switches at once: 0..17 back to back.
    pulse(18'h3FFFF, 18'h2AAAA);
    for (int i = 0; i < N; i++) push_ev(i, i[0]);
    cnt   = 0;
    first = -1;
    last  = -1;
    for (int c = 0; c < 30; c++) begin
      if (evt_valid) begin
        cnt++;
        if (first < 0) first = c;
        last = c;
      end
      tick();
    end
    chk("all18_count", 32'(cnt), 32'd18);
    chk("all18_b2b", 32'(last - first), 32'd17);
    chk("all18_left", 32'(q.size()), 32'd0);

    // Single pulse latency.
    push_ev(3, 1'b1);
    pulse(18'h00008, 18'h00008);
    chk("lat_n1_valid", 32'(evt_valid), 32'd0);
    tick();
    chk("lat_n2_valid", 32'(evt_valid), 32'd1);
    chk("lat_n2_idx", 32'(evt_idx), 32'd3);
    chk("lat_n2_level", 32'(evt_level), 32'd1);
    tick();
    chk("lat_n3_valid", 32'(evt_valid), 32'd0);
    mrr = 4;

    // Table vectors.
    for (int v = 0; v < 5; v++) begin
      model_push(vt[v].chg, vt[v].lvl);
      pulse(vt[v].chg, vt[v].lvl);
      n = 0;
      while (!evt_valid && n < 10) begin
        tick();
        n++;
      end
      chk($sformatf("vec%0d_first", v), 32'(evt_idx), 32'(vt[v].first));
      drain($sformatf("vec%0d", v));
    end

    // Stall with idx 5 held, 2 and 9 queued behind it.
    evt_ready = 1'b0;
    pulse(18'h00020, 18'h00020);
    tick();
    pulse(18'h00204, 18'h00200);
    push_ev(5, 1'b1);
    push_ev(9, 1'b1);
    push_ev(2, 1'b0);
    for (int c = 0; c < 10; c++) begin
      chk("stall_hold", {evt_valid, evt_level, 25'd0, evt_idx},
          {1'b1, 1'b1, 25'd0, 5'd5});
      tick();
    end
    evt_ready = 1'b1;
    drain("stall");

    // Overrun on bit 7 while slot is stalled on bit 0.
    evt_ready = 1'b0;
    pulse(18'h00001, 18'h00001);
    tick();
    pulse(18'h00080, 18'h00000);
    chk("ovr_none", 32'(ovr_flags), 32'd0);
    pulse(18'h00080, 18'h00080);
    chk("ovr_set", 32'(ovr_flags), 32'h80);
    push_ev(0, 1'b1);
    push_ev(7, 1'b1);
    evt_ready = 1'b1;
    drain("ovr");
    chk("ovr_sticky", 32'(ovr_flags), 32'h80);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_clr", 32'(ovr_flags), 32'd0);

    // Pulse on the bit being granted: re-queued, no overrun.
    push_ev(4, 1'b1);
    push_ev(4, 1'b0);
    pulse(18'h00010, 18'h00010);
    pulse(18'h00010, 18'h00000);
    drain("setwins");
    chk("setwins_ovr", 32'(ovr_flags), 32'd0);

    // Grants one cycle apart: timestamp delta.
    push_ev(1, 1'b1);
    push_ev(11, 1'b0);
    pulse(18'h00002, 18'h00002);
    pulse(18'h00800, 18'h00000);
    chk("ts_a_idx", 32'(evt_idx), 32'd1);
    t1 = evt_time;
    tick();
    chk("ts_b_idx", 32'(evt_idx), 32'd11);
    t2 = evt_time;
`ifdef SWEVT_TIMESTAMP_EN
    chk("ts_delta", 32'(t2 - t1), 32'd1);
`else
    chk("ts_tied", 32'({t1, t2}), 32'd0);
`endif
    drain("ts");

    // Reset while holding one event with 4 more pending.
    evt_ready = 1'b0;
    pulse(18'h07C00, 18'h07C00);
    tick();
    tick();
    chk("rstmid_pre", 32'(evt_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 32'(evt_valid), 32'd0);
    chk("rstmid_idx", 32'(evt_idx), 32'd0);
    q.delete();
    tick();
    #3 rst_n = 1'b1;
    evt_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    chk("rstmid_quiet", 32'(evt_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
